// File: rtl/jk_pkg.sv
// Shared definitions for JK-flop excitation logic.
//   - FSM state encodings for the excitation driver.
//   - Excitation table: for each {present Q, target Q} pair, the required
//     J and K terms, each being 0, 1 or don't-care.
//   - resolve_term: turns a table term into a concrete bit, given the value
//     to use for don't-care.
package jk_pkg;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_DRIVE = 2'b01;
   localparam logic [1:0] ST_CHECK = 2'b10;

   // Excitation term codes
   localparam logic [1:0] EX_0 = 2'b00;
   localparam logic [1:0] EX_1 = 2'b01;
   localparam logic [1:0] EX_X = 2'b10;

   // Tables indexed by {q, target}; 2 bits per entry, entry 0 in the LSBs.
   //   idx 0: 0->0  J=0 K=X
   //   idx 1: 0->1  J=1 K=X
   //   idx 2: 1->0  J=X K=1
   //   idx 3: 1->1  J=X K=0
   localparam logic [7:0] EXC_J_TBL = {EX_X, EX_X, EX_1, EX_0};
   localparam logic [7:0] EXC_K_TBL = {EX_0, EX_1, EX_X, EX_X};

   function automatic logic resolve_term(input logic [1:0] term, input logic dc_val);
      logic res;
      case (term)
         EX_0:    res = 1'b0;
         EX_1:    res = 1'b1;
         default: res = dc_val;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/jk_excitation.sv
// Pure combinational JK excitation mapping.
// Ports:
//   q    - present state of the flop
//   tgt  - desired next state
//   j, k - excitation inputs that move q to tgt (don't-care terms = DC_VAL)
import jk_pkg::*;

module jk_excitation #(
   parameter logic DC_VAL = 1'b0
) (
   input  logic q,
   input  logic tgt,
   output logic j,
   output logic k
);

   logic [2:0] base;

   // Each table entry is 2 bits wide, so the bit offset is {q,tgt}*2.
   assign base = {q, tgt, 1'b0};

   assign j = resolve_term(EXC_J_TBL[base +: 2], DC_VAL);
   assign k = resolve_term(EXC_K_TBL[base +: 2], DC_VAL);

endmodule

// File: rtl/jk_excitation_driver.sv
// Closed-loop driver for an external JK flip-flop.
// Accepts target bits over valid/ready, drives the J/K excitation that moves
// the flop's present Q to the target for exactly one clock, then checks the
// flop's new Q and counts completed checks and mismatches.
// Ports:
//   clk, reset         - clock, asynchronous active-high reset
//   clr                - synchronous clear of both counters (FSM unaffected)
//   tgt_valid/tgt_bit  - offered target bit
//   tgt_ready          - high in IDLE (and not in reset)
//   q_in               - Q of the driven flop
//   J, K               - registered excitation to the flop
//   busy               - high in DRIVE and CHECK
//   mismatch           - one-cycle pulse after a failed check
//   err_cnt, step_cnt  - saturating mismatch / completed-check counters
import jk_pkg::*;

module jk_excitation_driver #(
   parameter int   CNT_W  = 8,
   parameter logic DC_VAL = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             tgt_valid,
   input  logic             tgt_bit,
   output logic             tgt_ready,
   input  logic             q_in,
   output logic             J,
   output logic             K,
   output logic             busy,
   output logic             mismatch,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] step_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0] state;
   logic       tgt_latched;
   logic       j_exc;
   logic       k_exc;
   logic       accept;
   logic       check_now;
   logic       miss;

   jk_excitation #(.DC_VAL(DC_VAL)) u_exc (
      .q   (q_in),
      .tgt (tgt_bit),
      .j   (j_exc),
      .k   (k_exc)
   );

   // Ready is gated by reset so nothing appears accepted while reset is held.
   assign tgt_ready = (state == ST_IDLE) && !reset;
   assign busy      = (state == ST_DRIVE) || (state == ST_CHECK);
   assign accept    = tgt_valid && tgt_ready;
   assign check_now = (state == ST_CHECK);
   assign miss      = check_now && (q_in != tgt_latched);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         J           <= 1'b0;
         K           <= 1'b0;
         tgt_latched <= 1'b0;
         mismatch    <= 1'b0;
      end else begin
         // J/K are only non-zero for the single DRIVE cycle.
         J        <= 1'b0;
         K        <= 1'b0;
         mismatch <= miss;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  J           <= j_exc;
                  K           <= k_exc;
                  tgt_latched <= tgt_bit;
                  state       <= ST_DRIVE;
               end
            end
            ST_DRIVE: state <= ST_CHECK;
            ST_CHECK: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   // clr takes priority over any coincident increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_cnt <= '0;
         err_cnt  <= '0;
      end else if (clr) begin
         step_cnt <= '0;
         err_cnt  <= '0;
      end else begin
         if (check_now && (step_cnt != CNT_MAX))
            step_cnt <= step_cnt + CNT_ONE;
         if (miss && (err_cnt != CNT_MAX))
            err_cnt <= err_cnt + CNT_ONE;
      end
   end

endmodule
